fifo_unloader: RTL



---
 rtl/fifo_pkg.sv | 13 +
 rtl/fifo.sv | 30 +++
 rtl/fifo_unloader.sv | 84 ++++++++
 3 files changed

// File: rtl/fifo_pkg.sv
// Shared definitions for the delay-buffer fifo and its reader-side unloader.
package fifo_pkg;

    localparam int FIFO_DEPTH = 8;
    localparam int FIFO_BITS  = 64;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SHIFT   = 2'd1,
        PRESENT = 2'd2
    } unloader_state_t;

endpackage

// File: rtl/fifo.sv
// Delay-buffer fifo: a DEPTH-entry shift register. Each enabled cycle the
// oldest entry leaves on q and d enters as the newest entry.
module fifo
    import fifo_pkg::*;
#(
    parameter int DEPTH = FIFO_DEPTH,
    parameter int BITS  = FIFO_BITS
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            en,
    input  logic [BITS-1:0] d,
    output logic [BITS-1:0] q
);

    logic [BITS-1:0] mem [DEPTH];

    // Shift one entry toward the output on every enabled cycle
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else if (en) begin
            mem[0] <= d;
            for (int i = 1; i < DEPTH; i++) mem[i] <= mem[i-1];
        end
    end

    assign q = mem[DEPTH-1];

endmodule

// File: rtl/fifo_unloader.sv
// Reader-side controller for the delay-buffer fifo. On start it shifts the
// fifo for exactly DEPTH cycles, packs the words into one line (word 0 is
// the oldest) and offers the line over a valid/ready handshake.
// Optional build macro FIFO_UNLOADER_RECIRC_EN: feed each drained word back
// into the fifo so a drain leaves the fifo contents unchanged.
module fifo_unloader
    import fifo_pkg::*;
#(
    parameter int DEPTH = FIFO_DEPTH,
    parameter int BITS  = FIFO_BITS
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    output logic                  fifo_en,
    output logic [BITS-1:0]       fifo_d,
    input  logic [BITS-1:0]       fifo_q,
    output logic [DEPTH*BITS-1:0] line_data,
    output logic                  line_valid,
    input  logic                  line_ready,
    output logic                  busy,
    output logic                  done
);

    localparam int            CW   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [CW-1:0] LAST = CW'(DEPTH - 1);

    unloader_state_t state, state_nxt;
    logic [CW-1:0]   cnt;

    // State register
    always_ff @(posedge clk) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    // Next-state and state-decoded outputs
    always_comb begin
        state_nxt  = state;
        fifo_en    = 1'b0;
        line_valid = 1'b0;
        busy       = 1'b0;
        fifo_d     = '0;
        case (state)
            IDLE: begin
                if (start) state_nxt = SHIFT;
            end
            SHIFT: begin
                fifo_en = 1'b1;
                busy    = 1'b1;
`ifdef FIFO_UNLOADER_RECIRC_EN
                fifo_d  = fifo_q;
`endif
                if (cnt == LAST) state_nxt = PRESENT;
            end
            PRESENT: begin
                line_valid = 1'b1;
                busy       = 1'b1;
                if (line_ready) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Word counter: runs only while shifting, back to zero on the last word
    always_ff @(posedge clk) begin
        if (!rst_n)                         cnt <= '0;
        else if (state == SHIFT && cnt != LAST) cnt <= cnt + 1'b1;
        else                                cnt <= '0;
    end

    // Capture each shifted-out word into its slot; held outside SHIFT
    always_ff @(posedge clk) begin
        if (!rst_n)              line_data <= '0;
        else if (state == SHIFT) line_data[int'(cnt)*BITS +: BITS] <= fifo_q;
    end

    // Completion pulse on the cycle after the handshake
    always_ff @(posedge clk) begin
        if (!rst_n) done <= 1'b0;
        else        done <= (state == PRESENT) && line_ready;
    end

endmodule
